stream_to_ddr_wr: RTL
=====================

# stream_to_ddr_wr

Write-DMA master that sits directly upstream of the DDR AXI slave write channels. It accepts a 32-bit word stream, buffers it in a small FIFO, and issues incrementing AXI write bursts of up to MAX_BURST beats starting at a programmed address. It waits for each write response before issuing the next burst. Completion is flagged with a done pulse and a sticky error flag.

## Interface
- WR_ID, 4'h0, constant AXI ID driven on MASTER_WR_ADDR_ID; expected on MASTER_WR_BACK_ID.
- MAX_BURST, 16, beats per burst, 1..256.
- FIFO_DEPTH, 32, words, power of 2, must be ≥ MAX_BURST.

Ports:
- clk  in  1  single clock; the DDR slave clock.
- rstn  in  1  reset, asynchronous active-low; all state is cleared on assertion.
- start  in  1  1-cycle request; ignored while busy.
- start_addr  in  32  byte address; bits [1:0] are forced to 0.
- start_words  in  16  number of 32-bit words to write.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  1-cycle pulse at the end of a transfer.
- err  out  1  sticky; set by a bad response; cleared on an accepted start.
- STRM_DATA  in  32  stream word.
- STRM_VALID  in  1  stream valid.
- STRM_READY  out  1  stream ready.
- MASTER_WR_ADDR_ID  out  4  =WR_ID.
- MASTER_WR_ADDR  out  32  burst start address.
- MASTER_WR_ADDR_LEN  out  8  beats−1.
- MASTER_WR_ADDR_BURST  out  2  constant 2'b01 (INCR).
- MASTER_WR_ADDR_VALID  out  1  write address valid.
- MASTER_WR_ADDR_READY  in  1  write address ready.
- MASTER_WR_DATA  out  32  write data.
- MASTER_WR_STRB  out  4  constant 4'hF.
- MASTER_WR_DATA_LAST  out  1  last beat of burst.
- MASTER_WR_DATA_VALID  out  1  write data valid.
- MASTER_WR_DATA_READY  in  1  write data ready.
- MASTER_WR_BACK_ID  in  4  response ID.
- MASTER_WR_BACK_RESP  in  2  response code.
- MASTER_WR_BACK_VALID  in  1  response valid.
- MASTER_WR_BACK_READY  out  1  response ready.

## Operation
- **States:** IDLE, FILL, ADDR, DATA, RESP.
- **IDLE:**
  - start with start_words≠0 latches addr, remaining=start_words and accepted=0, clears err, then goes to FILL.
  - start with start_words=0 pulses done the next cycle and stays in IDLE.
- **Stream intake (any non-IDLE state):** STRM_READY = busy && FIFO not full && accepted < start_words. Each handshake pushes one word to the FIFO and increments accepted. No word beyond start_words is ever taken.
- **FILL:**
  - beats = min(remaining, MAX_BURST, (4096 − addr[11:0])>>2). The 4K term applies only with WR_4K_SPLIT_EN.
  - Move to ADDR once FIFO count ≥ beats.
- **ADDR:**
  - Drive ADDR=addr, LEN=beats−1 and hold VALID.
  - On READY, go to DATA.
- **DATA:**
  - WDATA is the FIFO head (first-word fall-through).
  - WVALID is held high; the FIFO already holds every beat.
  - Each W handshake pops one word and increments the beat counter.
  - LAST is high when beat counter = beats−1.
  - After the LAST handshake, go to RESP.
- **RESP:**
  - BREADY=1.
  - On BVALID: if RESP≠2'b00 or BACK_ID≠WR_ID, set err.
  - Then addr += beats×4 and remaining −= beats.
  - If remaining=0, pulse done and go to IDLE; otherwise go to FILL.
- **Ordering:** exactly one burst is outstanding. W beats are never issued before their AW handshake.
- **Arithmetic:** addr is 32-bit and wraps modulo 2^32 with no error. Beat counter and LEN are 8 bits.

## Timing
- **Reset values:** all outputs 0, except MASTER_WR_ADDR_ID=WR_ID, MASTER_WR_ADDR_BURST=2'b01 and MASTER_WR_STRB=4'hF. The FIFO is empty.
- **Start:** accepted on cycle 0; busy and STRM_READY high from cycle 1.
- **Address phase:** AWVALID rises the cycle after FIFO count reaches beats. With a continuous stream and MAX_BURST=16, that is cycle 18.
- **Data phase:** W beats go at 1/cycle while WREADY is high. WVALID does not drop within a burst.
- **Response phase:** B is accepted the same cycle BVALID is seen. done is registered one cycle later.
- **Simultaneous events:** stream push and W pop in the same cycle leave the FIFO count unchanged.
- **Reset mid-transfer:** asynchronous; outputs return to reset values immediately. Recovery of a partially written slave is the system's responsibility, because the slave shares rstn.

## Configuration
- **Macro:** WR_4K_SPLIT_EN.
- **Defined:** bursts never cross a 4 KB boundary (AXI rule).
- **Undefined:** beats = min(remaining, MAX_BURST) only. This is smaller logic and is legal only for slaves that tolerate crossing, such as the DDR slave.

## Structure
- **Package dma_pkg:**
  - state enum
  - BURST_INCR=2'b01
  - RESP_OKAY=2'b00
  - BOUNDARY_4K=4096
- **Sub-module dma_sync_fifo:**
  - first-word fall-through synchronous FIFO, 32-bit words, depth FIFO_DEPTH.
  - Outputs: count, full, empty.

## Test plan
- **Multi-burst transfer:** start_addr=0x0000_0100, start_words=40, continuous stream, slave always ready → bursts LEN 15/15/7 at 0x100/0x140/0x180. Data matches the stream in order, one done pulse, err=0.
- **4K boundary crossing:** start_addr=0x0000_0FF0, start_words=8.
  - With WR_4K_SPLIT_EN: LEN 3 @0xFF0, then LEN 3 @0x1000.
  - Without the macro: a single LEN 7 @0xFF0.
- **Backpressure:** random AWREADY/WREADY/BVALID delays plus stream gaps → WVALID never drops mid-burst, LAST only on beat LEN, STRM_READY low when the FIFO is full and after the 40th word.
- **Error response:** the second burst's B returns RESP=2'b10 → err rises and the transfer still completes with done. The next start clears err.
- **Edge starts:** start_words=0 → done one cycle later with no AWVALID. A start pulse while busy is ignored and the addresses are unchanged.
- **Reset mid-transfer:** rstn asserted mid-DATA → all outputs return to reset values asynchronously. After release, a start of 4 words to 0x200 completes normally.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared types and constants for the stream-to-DDR write DMA.
package dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FILL = 3'd1,
    ST_ADDR = 3'd2,
    ST_DATA = 3'd3,
    ST_RESP = 3'd4
  } state_e;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam int         BOUNDARY_4K = 4096;

endpackage

// File: rtl/dma_sync_fifo.sv
// First-word fall-through synchronous FIFO of 32-bit words; head is valid whenever not empty.
module dma_sync_fifo #(
  parameter int DEPTH = 32
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push_i,
  input  logic [31:0]                data_i,
  input  logic                       pop_i,
  output logic [31:0]                data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          push_ok;
  logic          pop_ok;

  assign count_o = wr_ptr_q - rd_ptr_q;
  assign full_o  = (count_o == CW'(DEPTH));
  assign empty_o = (count_o == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Storage carries no reset so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/stream_to_ddr_wr.sv
// Write-DMA master: buffers a word stream and issues one INCR burst at a time to an AXI slave.
// Define WR_4K_SPLIT_EN to keep every burst inside a 4 KB page.
module stream_to_ddr_wr
  import dma_pkg::*;
#(
  parameter logic [3:0] WR_ID      = 4'h0,
  parameter int         MAX_BURST  = 16,
  parameter int         FIFO_DEPTH = 32
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [31:0] start_addr,
  input  logic [15:0] start_words,
  output logic        busy,
  output logic        done,
  output logic        err,
  input  logic [31:0] STRM_DATA,
  input  logic        STRM_VALID,
  output logic        STRM_READY,
  output logic [3:0]  MASTER_WR_ADDR_ID,
  output logic [31:0] MASTER_WR_ADDR,
  output logic [7:0]  MASTER_WR_ADDR_LEN,
  output logic [1:0]  MASTER_WR_ADDR_BURST,
  output logic        MASTER_WR_ADDR_VALID,
  input  logic        MASTER_WR_ADDR_READY,
  output logic [31:0] MASTER_WR_DATA,
  output logic [3:0]  MASTER_WR_STRB,
  output logic        MASTER_WR_DATA_LAST,
  output logic        MASTER_WR_DATA_VALID,
  input  logic        MASTER_WR_DATA_READY,
  input  logic [3:0]  MASTER_WR_BACK_ID,
  input  logic [1:0]  MASTER_WR_BACK_RESP,
  input  logic        MASTER_WR_BACK_VALID,
  output logic        MASTER_WR_BACK_READY
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [15:0]   remaining_q, remaining_d;
  logic [15:0]   words_q, words_d;
  logic [15:0]   accepted_q, accepted_d;
  logic [7:0]    beat_q, beat_d;
  logic          err_q, err_d;
  logic          done_q, done_d;

  logic [8:0]    beats;
  logic [8:0]    beats_rem;
  logic [7:0]    len;
  logic          last;
  logic          aw_valid;
  logic          w_valid;
  logic          strm_ready;
  logic          strm_hs;
  logic          w_hs;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic [31:0]   fifo_head;

  assign beats_rem = (remaining_q < 16'(MAX_BURST)) ? remaining_q[8:0] : 9'(MAX_BURST);

`ifdef WR_4K_SPLIT_EN
  logic [12:0] room_bytes;
  logic [10:0] room_words;
  // addr is word aligned, so the room left in the page is a whole number of words.
  assign room_bytes = 13'(BOUNDARY_4K) - {1'b0, addr_q[11:0]};
  assign room_words = room_bytes[12:2];
  assign beats      = ({2'b00, beats_rem} < room_words) ? beats_rem : room_words[8:0];
`else
  assign beats      = beats_rem;
`endif

  assign len        = 8'(beats - 9'd1);
  assign busy       = (state_q != ST_IDLE);
  assign strm_ready = busy && !fifo_full && (accepted_q < words_q);
  assign strm_hs    = STRM_VALID && strm_ready;
  assign aw_valid   = (state_q == ST_ADDR);
  assign w_valid    = (state_q == ST_DATA) && !fifo_empty;
  assign w_hs       = w_valid && MASTER_WR_DATA_READY;
  assign last       = w_valid && (beat_q == len);

  dma_sync_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (strm_hs),
    .data_i  (STRM_DATA),
    .pop_i   (w_hs),
    .data_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    words_d     = words_q;
    accepted_d  = accepted_q;
    beat_d      = beat_q;
    err_d       = err_q;
    done_d      = 1'b0;

    if (strm_hs) accepted_d = accepted_q + 16'd1;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          err_d = 1'b0;
          if (start_words != 16'd0) begin
            addr_d      = start_addr & 32'hFFFF_FFFC;
            remaining_d = start_words;
            words_d     = start_words;
            accepted_d  = 16'd0;
            state_d     = ST_FILL;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_FILL: begin
        if (32'(fifo_count) >= 32'(beats)) state_d = ST_ADDR;
      end
      ST_ADDR: begin
        beat_d = 8'd0;
        if (MASTER_WR_ADDR_READY) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (w_hs) begin
          beat_d = beat_q + 8'd1;
          if (last) state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (MASTER_WR_BACK_VALID) begin
          if (MASTER_WR_BACK_RESP != RESP_OKAY || MASTER_WR_BACK_ID != WR_ID) err_d = 1'b1;
          addr_d      = addr_q + {21'd0, beats, 2'b00};
          remaining_d = remaining_q - 16'(beats);
          if (remaining_d == 16'd0) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_FILL;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      words_q     <= '0;
      accepted_q  <= '0;
      beat_q      <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      words_q     <= words_d;
      accepted_q  <= accepted_d;
      beat_q      <= beat_d;
      err_q       <= err_d;
      done_q      <= done_d;
    end
  end

  // Address, length and data are zeroed outside their phase so reset shows all-zero buses.
  assign done                 = done_q;
  assign err                  = err_q;
  assign STRM_READY           = strm_ready;
  assign MASTER_WR_ADDR_ID    = WR_ID;
  assign MASTER_WR_ADDR_BURST = BURST_INCR;
  assign MASTER_WR_STRB       = 4'hF;
  assign MASTER_WR_ADDR_VALID = aw_valid;
  assign MASTER_WR_ADDR       = aw_valid ? addr_q : 32'd0;
  assign MASTER_WR_ADDR_LEN   = aw_valid ? len : 8'd0;
  assign MASTER_WR_DATA_VALID = w_valid;
  assign MASTER_WR_DATA       = w_valid ? fifo_head : 32'd0;
  assign MASTER_WR_DATA_LAST  = last;
  assign MASTER_WR_BACK_READY = (state_q == ST_RESP);

endmodule
